// File: rtl/car_game_pkg.sv
// Shared constants, requester indices and scheduler state encoding for the car game
// sprite plotting path.
package car_game_pkg;

   localparam int         SPRITE_BITS = 3;
   localparam int         ADDR_W      = 2 * SPRITE_BITS;
   localparam int         SCREEN_W    = 160;
   localparam int         SCREEN_H    = 120;
   localparam logic [2:0] TRANSPARENT = 3'b000;

   localparam logic [1:0] REQ_ERASE = 2'd0;
   localparam logic [1:0] REQ_CAR   = 2'd1;
   localparam logic [1:0] REQ_OBS   = 2'd2;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      case (oh)
         3'b010:  return REQ_CAR;
         3'b100:  return REQ_OBS;
         default: return REQ_ERASE;
      endcase
   endfunction

endpackage

// File: rtl/sprite_plot_scheduler_if.sv
// Requester, sprite ROM and VGA adapter signals shared by the plot scheduler.
interface sprite_plot_scheduler_if;
   import car_game_pkg::*;

   logic [2:0]        req;
   logic [23:0]       req_x;
   logic [20:0]       req_y;
   logic [2:0]        grant;
   logic [2:0]        done;
   logic              busy;
   logic [ADDR_W-1:0] rom_addr;
   logic [2:0]        back_colour;
   logic [2:0]        car_colour;
   logic [2:0]        obs_colour;
   logic [7:0]        oX;
   logic [6:0]        oY;
   logic [2:0]        oColour;
   logic              plot;

   modport master (
      output req, req_x, req_y, back_colour, car_colour, obs_colour,
      input  grant, done, busy, rom_addr, oX, oY, oColour, plot
   );

   modport slave (
      input  req, req_x, req_y, back_colour, car_colour, obs_colour,
      output grant, done, busy, rom_addr, oX, oY, oColour, plot
   );

endinterface

// File: rtl/sprite_plot_scheduler_rr_arbiter3.sv
// Three-way round-robin arbiter; the search starts just after the last accepted winner.
module rr_arbiter3
   import car_game_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic       advance,
   output logic [2:0] win
);

   logic [1:0] last;

   always_comb begin
      win = '0;
      case (last)
         2'd0: begin
            if (req[1])      win = 3'b010;
            else if (req[2]) win = 3'b100;
            else if (req[0]) win = 3'b001;
         end
         2'd1: begin
            if (req[2])      win = 3'b100;
            else if (req[0]) win = 3'b001;
            else if (req[1]) win = 3'b010;
         end
         default: begin
            if (req[0])      win = 3'b001;
            else if (req[1]) win = 3'b010;
            else if (req[2]) win = 3'b100;
         end
      endcase
   end

   // Pointer resets to "last = 2" so requester 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst)                  last <= 2'd2;
      else if (advance && |win) last <= onehot_to_idx(win);
   end

endmodule

// File: rtl/sprite_plot_scheduler.sv
// Grants one 8x8 sprite job at a time, scans its ROM and drives the VGA adapter write
// port, delaying pixel coordinates one cycle to line up with the ROM read latency.
module sprite_plot_scheduler #(
   parameter int         SPRITE_BITS = car_game_pkg::SPRITE_BITS,
   parameter logic [2:0] TRANSPARENT = car_game_pkg::TRANSPARENT,
   parameter int         SCREEN_W    = car_game_pkg::SCREEN_W,
   parameter int         SCREEN_H    = car_game_pkg::SCREEN_H
) (
   input logic                   CLOCK_50,
   input logic                   Reset,
   sprite_plot_scheduler_if.slave bus
);
   import car_game_pkg::*;

   localparam int AW = 2 * SPRITE_BITS;

   state_t                 state, state_nx;
   logic [AW-1:0]          addr;
   logic [2:0]             win, grant_r, done_r;
   logic [1:0]             idx;
   logic [7:0]             org_x, sel_x;
   logic [6:0]             org_y, sel_y;
   logic                   take, vld_p0, busy;
   logic [SPRITE_BITS-1:0] col, row;
   logic [7:0]             x_p0, x_p1;
   logic [6:0]             y_p0, y_p1;
   logic [1:0]             idx_p1;
   logic                   vld_p1;
   logic [2:0]             colour_p1;
   logic                   on_screen, opaque;

   rr_arbiter3 u_arb (
      .clk     (CLOCK_50),
      .rst     (Reset),
      .req     (bus.req),
      .advance (take),
      .win     (win)
   );

   always_ff @(posedge CLOCK_50) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      take     = 1'b0;
      vld_p0   = 1'b0;
      busy     = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            take = |bus.req;
            if (take) state_nx = SCAN;
         end
         SCAN: begin
            vld_p0 = 1'b1;
            if (&addr) state_nx = DRAIN;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      case (onehot_to_idx(win))
         REQ_CAR: begin sel_x = bus.req_x[15:8];  sel_y = bus.req_y[13:7];  end
         REQ_OBS: begin sel_x = bus.req_x[23:16]; sel_y = bus.req_y[20:14]; end
         default: begin sel_x = bus.req_x[7:0];   sel_y = bus.req_y[6:0];   end
      endcase
   end

   assign col  = addr[SPRITE_BITS-1:0];
   assign row  = addr[AW-1:SPRITE_BITS];
   assign x_p0 = org_x + 8'(col);
   assign y_p0 = org_y + 7'(row);

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         addr    <= '0;
         grant_r <= '0;
         done_r  <= '0;
         idx     <= REQ_ERASE;
         vld_p1  <= 1'b0;
      end else begin
         grant_r <= take ? win : 3'b000;
         done_r  <= (state == SCAN && &addr) ? 3'(3'b001 << idx) : 3'b000;
         addr    <= (state == SCAN) ? addr + 1'b1 : '0;
         if (take) idx <= onehot_to_idx(win);
         vld_p1  <= vld_p0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (take) begin
         org_x <= sel_x;
         org_y <= sel_y;
      end
   end

   // ---- stage p1: coordinates and owner aligned with ROM data ----
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         x_p1   <= '0;
         y_p1   <= '0;
         idx_p1 <= REQ_ERASE;
      end else begin
         x_p1   <= x_p0;
         y_p1   <= y_p0;
         idx_p1 <= idx;
      end
   end

   always_comb begin
      case (idx_p1)
         REQ_CAR: colour_p1 = bus.car_colour;
         REQ_OBS: colour_p1 = bus.obs_colour;
         default: colour_p1 = bus.back_colour;
      endcase
   end

   assign on_screen = (int'(x_p1) < SCREEN_W) && (int'(y_p1) < SCREEN_H);
   assign opaque    = (idx_p1 == REQ_ERASE) || (colour_p1 != TRANSPARENT);

   assign bus.grant    = grant_r;
   assign bus.done     = done_r;
   assign bus.busy     = busy;
   assign bus.rom_addr = addr;
   assign bus.oX       = x_p1;
   assign bus.oY       = y_p1;
   assign bus.oColour  = vld_p1 ? colour_p1 : 3'b000;
   assign bus.plot     = vld_p1 && on_screen && opaque;

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Scoreboard bench for sprite_plot_scheduler: stimulus pushes the expected grant, done
// and visible-pixel stream; a negedge monitor pops and compares what the DUT presents.
module tb_sprite_plot_scheduler;
   import car_game_pkg::*;

   typedef struct {
      int x;
      int y;
      int c;
      int off;
   } pix_t;

   logic clk = 1'b0;
   logic rst;

   sprite_plot_scheduler_if bus ();

   sprite_plot_scheduler dut (
      .CLOCK_50 (clk),
      .Reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [2:0] rom [3][64];
   pix_t       pq[$];
   int         gq[$];
   int         dq[$];
   int         last_grant_cyc = 0;
   int         plot_cnt = 0;
   bit         chk_idle = 0;
   int         last_win = 2;
   int         xs[3];
   int         ys[3];

   // Sprite ROMs: one cycle of read latency.
   always @(posedge clk) begin
      cyc             <= cyc + 1;
      bus.back_colour <= rom[0][bus.rom_addr];
      bus.car_colour  <= rom[1][bus.rom_addr];
      bus.obs_colour  <= rom[2][bus.rom_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: every pixel of the 8x8 sprite, kept if on screen and not transparent.
   task automatic push_job(input int r, input int x, input int y);
      pix_t p;
      gq.push_back(1 << r);
      dq.push_back(1 << r);
      for (int a = 0; a < 64; a++) begin
         p.x   = (x + (a % 8)) % 256;
         p.y   = (y + (a / 8)) % 128;
         p.c   = int'(rom[r][a]);
         p.off = a + 1;
         if (p.x < 160 && p.y < 120 && (r == 0 || p.c != 0)) pq.push_back(p);
      end
   endtask

   always @(negedge clk) begin
      pix_t p;
      if (chk_idle) begin
         check("busy_after_done", int'(bus.busy), 0);
         chk_idle = 0;
      end
      if (bus.grant != 3'b000) begin
         if (gq.size() == 0) check("unexpected_grant", int'(bus.grant), 0);
         else                check("grant", int'(bus.grant), gq.pop_front());
         check("busy_at_grant", int'(bus.busy), 1);
         check("addr_at_grant", int'(bus.rom_addr), 0);
         last_grant_cyc = cyc;
      end
      if (bus.plot) begin
         plot_cnt++;
         if (pq.size() == 0) check("unexpected_plot", int'(bus.plot), 0);
         else begin
            p = pq.pop_front();
            check("pix_x", int'(bus.oX), p.x);
            check("pix_y", int'(bus.oY), p.y);
            check("pix_colour", int'(bus.oColour), p.c);
            check("pix_time", cyc - last_grant_cyc, p.off);
         end
      end
      if (bus.done != 3'b000) begin
         if (dq.size() == 0) check("unexpected_done", int'(bus.done), 0);
         else                check("done", int'(bus.done), dq.pop_front());
         check("done_time", cyc - last_grant_cyc, 64);
         chk_idle = 1;
      end
   end

   task automatic wait_grant(output int gcyc, output logic [2:0] g);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.grant != 3'b000) break;
      end
      check("grant_seen", int'(bus.grant != 3'b000), 1);
      gcyc = cyc;
      g    = bus.grant;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      check("idle_seen", int'(bus.busy), 0);
   endtask

   task automatic set_origin(input int r, input int x, input int y);
      logic [7:0] bx;
      logic [6:0] by;
      bx = 8'(x);
      by = 7'(y);
      bus.req_x[8*r +: 8] = bx;
      bus.req_y[7*r +: 7] = by;
      xs[r] = x;
      ys[r] = y;
   endtask

   task automatic run_job(input int r, input int x, input int y);
      int         gc;
      logic [2:0] g;
      set_origin(r, x, y);
      push_job(r, x, y);
      bus.req[r] = 1'b1;
      wait_grant(gc, g);
      bus.req = 3'b000;
      wait_idle();
      last_win = r;
   endtask

   // Requests in 'set' go up together; each either drops right after its grant or all
   // stay high until n grants have been issued.
   task automatic run_burst(input logic [2:0] set, input int n, input bit drop_each);
      int         ptr, w, gc, prev;
      logic [2:0] act, g;
      bit         found;
      ptr = last_win;
      act = set;
      w   = 0;
      for (int k = 0; k < n; k++) begin
         found = 0;
         for (int s = 1; s <= 3; s++) begin
            if (!found && act[(ptr + s) % 3]) begin
               w     = (ptr + s) % 3;
               found = 1;
            end
         end
         push_job(w, xs[w], ys[w]);
         ptr = w;
         if (drop_each) act[w] = 1'b0;
      end
      bus.req = set;
      prev    = 0;
      for (int k = 0; k < n; k++) begin
         wait_grant(gc, g);
         if (k > 0) check("grant_spacing", gc - prev, 66);
         prev = gc;
         if (drop_each) bus.req = bus.req & ~g;
         if (k == n - 1) bus.req = 3'b000;
      end
      wait_idle();
      last_win = ptr;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      last_win = 2;
   endtask

   task automatic fill_rom(input int r);
      for (int a = 0; a < 64; a++) rom[r][a] = 3'($urandom_range(0, 7));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         gc;
      logic [2:0] g;
      int         r;
      bus.req   = 3'b000;
      bus.req_x = '0;
      bus.req_y = '0;
      for (int i = 0; i < 3; i++) begin
         fill_rom(i);
         xs[i] = 0;
         ys[i] = 0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_grant", int'(bus.grant), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_plot", int'(bus.plot), 0);
      check("rst_addr", int'(bus.rom_addr), 0);
      check("rst_ox", int'(bus.oX), 0);
      check("rst_oy", int'(bus.oY), 0);
      check("rst_colour", int'(bus.oColour), 0);
      rst = 1'b0;
      last_win = 2;

      // Car at (75,70) with colour = column: column 0 transparent.
      for (int a = 0; a < 64; a++) rom[1][a] = 3'(a % 8);
      plot_cnt = 0;
      run_job(1, 75, 70);
      check("car_plot_count", plot_cnt, 56);

      // Erase at origin with all-zero background: nothing suppressed.
      for (int a = 0; a < 64; a++) rom[0][a] = 3'b000;
      plot_cnt = 0;
      run_job(0, 0, 0);
      check("erase_plot_count", plot_cnt, 64);

      // Obstacle clipped at the bottom-right corner.
      for (int a = 0; a < 64; a++) rom[2][a] = 3'b100;
      plot_cnt = 0;
      run_job(2, 156, 116);
      check("clip_plot_count", plot_cnt, 16);

      // All three held from reset: fixed 0,1,2,0,1 rotation, 66 cycles apart.
      for (int i = 0; i < 3; i++) begin
         fill_rom(i);
         set_origin(i, $urandom_range(0, 255), $urandom_range(0, 127));
      end
      do_reset();
      run_burst(3'b111, 5, 1'b0);

      // Reset in the middle of a car job.
      fill_rom(1);
      set_origin(1, 40, 30);
      push_job(1, 40, 30);
      bus.req[1] = 1'b1;
      wait_grant(gc, g);
      bus.req = 3'b000;
      for (int i = 0; i < 100; i++) begin
         if (bus.rom_addr == 6'd20) break;
         @(negedge clk);
      end
      check("addr20_seen", int'(bus.rom_addr), 20);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pq.delete();
      dq.delete();
      last_win = 2;
      @(negedge clk);
      check("abort_plot", int'(bus.plot), 0);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_done", int'(bus.done), 0);
      repeat (70) @(negedge clk);
      run_job(1, 12, 90);

      // Origin bus changes after grant must not move the job.
      fill_rom(1);
      set_origin(1, 10, 10);
      push_job(1, 10, 10);
      bus.req[1] = 1'b1;
      wait_grant(gc, g);
      bus.req = 3'b000;
      repeat (4) @(negedge clk);
      bus.req_x[15:8] = 8'd100;
      wait_idle();
      last_win = 1;

      // Randomized single jobs.
      for (int k = 0; k < 12; k++) begin
         r = $urandom_range(0, 2);
         fill_rom(r);
         run_job(r, $urandom_range(0, 255), $urandom_range(0, 127));
      end

      // Randomized simultaneous requests, each dropping after its grant.
      for (int k = 0; k < 5; k++) begin
         logic [2:0] set;
         set = 3'($urandom_range(1, 7));
         for (int i = 0; i < 3; i++) begin
            fill_rom(i);
            set_origin(i, $urandom_range(0, 255), $urandom_range(0, 127));
         end
         run_burst(set, int'(set[0]) + int'(set[1]) + int'(set[2]), 1'b1);
      end

      repeat (5) @(negedge clk);
      check("pixels_left", pq.size(), 0);
      check("grants_left", gq.size(), 0);
      check("dones_left", dq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
